dmem_io: RTL
============

DMEM_IO -- requirements
Module: dmem_io

Interface
REQ-001 Parameter RAM_WORDS, 64, data RAM depth in 32-bit words (power of two).
REQ-002 Parameter FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 MemWrite  input  1  store strobe from the core, qualifies ALUResult/WriteData.
REQ-006 ALUResult  input  32  byte address from the core; bits [1:0] ignored (word access only).
REQ-007 WriteData  input  32  store data from the core.
REQ-008 ReadData  output  32  load data to the core, combinational from ALUResult.
REQ-009 leds  output  8  LED register contents.
REQ-010 tx_data  output  8  FIFO head byte.
REQ-011 tx_valid  output  1  FIFO non-empty.
REQ-012 tx_ready  input  1  sink accepts tx_data this cycle.

Function
REQ-013 Address map SHALL be: 0x000-0x0FF RAM (word index ALUResult[7:2]), 0x100 LED, 0x104 TX, 0x108 TIMER; all other addresses unmapped.
REQ-014 ReadData SHALL be valid in the same cycle as ALUResult (zero-latency read, single-cycle core).
REQ-015 RAM write SHALL occur at the clock edge when MemWrite=1 and address in RAM range; read of the same word in that cycle returns old contents.
REQ-016 LED write SHALL load WriteData[7:0] into leds at the edge; LED read returns {24'b0, leds}.
REQ-017 TX write with FIFO not full SHALL push WriteData[7:0] at the edge.
REQ-018 TX write with FIFO full and no pop that cycle SHALL drop the byte and set sticky overflow flag.
REQ-019 TX write with FIFO full and pop in same cycle SHALL be accepted; occupancy unchanged.
REQ-020 TX read SHALL return {29'b0, overflow, full, empty}.
REQ-021 tx_valid SHALL equal !empty; tx_data SHALL equal head entry, stable while tx_valid=1 and tx_ready=0.
REQ-022 Pop SHALL occur at an edge where tx_valid=1 and tx_ready=1; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 Push into empty FIFO SHALL assert tx_valid the following cycle (no same-cycle bypass).
REQ-024 Timer SHALL increment by 1 every cycle, wrap 0xFFFFFFFF -> 0x00000000; TIMER read returns current value.
REQ-025 TIMER write SHALL clear timer to 0 at the edge, taking priority over increment (value 0 next cycle, 1 the cycle after).
REQ-026 Unmapped reads SHALL return 0; unmapped writes SHALL change no state.
REQ-027 MemWrite=0 SHALL change no RAM, LED, FIFO or overflow state regardless of address.

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) clear leds=0, timer=0, FIFO pointers and count=0, overflow=0, hence tx_valid=0.
REQ-029 RAM contents SHALL NOT be reset; reads before first write are undefined.
REQ-030 Reset mid-transfer SHALL flush FIFO without handshake; tx_valid drops in the reset cycle regardless of tx_ready.
REQ-031 First timer increment SHALL occur at the first rising edge after reset deasserts.

Verification
REQ-032 RAM: store 0xDEADBEEF at 0x004, store 0x12345678 at 0x0FC, load both -> exact values; load 0x006 -> 0xDEADBEEF.
REQ-033 LED/unmapped: store 0xFFFFFFA5 at 0x100 -> leds=0xA5, read 0x100 -> 0x000000A5; store to 0x200 then read 0x200 -> 0, leds unchanged.
REQ-034 FIFO: tx_ready=0, store 0x11,0x22,0x33,0x44,0x55 to 0x104 -> status 0x2 after 4th, 0x6 after 5th; raise tx_ready -> tx_data 0x11,0x22,0x33,0x44 on consecutive cycles, then tx_valid=0, status 0x5.
REQ-035 Full with simultaneous pop: FIFO full, tx_ready=1, store 0x66 -> accepted, count stays 4, 0x66 emerges last, overflow unchanged.
REQ-036 Timer: after reset read 0x108 at cycle 10 -> 10; store to 0x108 -> reads 0 then 1 on following cycles; force timer 0xFFFFFFFF -> next 0.
REQ-037 Reset mid-operation: FIFO holding 3 bytes, leds=0x3C, assert reset between edges -> tx_valid=0, leds=0 without waiting for clk; after release status=0x1.

Source files
------------

// File: rtl/dmem_io_if.sv
// Core-side data-memory bus plus LED and TX byte-stream signals of the dmem_io block.
// The slave modport is the dmem_io view; the master modport is the core/sink view.
interface dmem_io_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output MemWrite, ALUResult, WriteData, tx_ready,
        input  ReadData, leds, tx_data, tx_valid
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData, tx_ready,
        output ReadData, leds, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_io.sv
// Data memory and memory-mapped I/O for a single-cycle core.
// Contains word RAM, an LED register, a TX byte FIFO with sticky overflow, and a free-running timer.
module dmem_io #(
    parameter int unsigned RAM_WORDS  = 64,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    dmem_io_if.slave   bus
);

    localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    logic [31:0]        r_ram [RAM_WORDS];
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [7:0]         r_leds;
    logic [31:0]        r_timer;

    logic              w_sel_ram;
    logic              w_sel_led;
    logic              w_sel_tx;
    logic              w_sel_timer;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_unused;

    // Word-granular decode; the byte offset bits carry no meaning here.
    assign w_sel_ram   = (bus.ALUResult[31:8] == 24'h0);
    assign w_sel_led   = (bus.ALUResult[31:2] == 30'h40);
    assign w_sel_tx    = (bus.ALUResult[31:2] == 30'h41);
    assign w_sel_timer = (bus.ALUResult[31:2] == 30'h42);
    assign w_ram_idx   = bus.ALUResult[RAM_AW+1:2];
    assign w_unused    = &{1'b0, bus.ALUResult[1:0]};

    assign w_empty    = (r_count == CNT_W'(0));
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop      = !w_empty && bus.tx_ready;
    assign w_push_req = bus.MemWrite && w_sel_tx;
    // A simultaneous pop frees the slot the incoming byte lands in.
    assign w_push     = w_push_req && (!w_full || w_pop);

    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = r_fifo[r_rd_ptr];
    assign bus.leds     = r_leds;

    // Storage arrays are intentionally not reset.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && w_sel_ram) begin
            r_ram[w_ram_idx] <= bus.WriteData;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.WriteData[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_leds <= '0;
        end else if (bus.MemWrite && w_sel_led) begin
            r_leds <= bus.WriteData[7:0];
        end
    end

    // Clear on write wins over the free-running increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (bus.MemWrite && w_sel_timer) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    always_comb begin
        bus.ReadData = '0;
        if (w_sel_ram) begin
            bus.ReadData = r_ram[w_ram_idx];
        end else if (w_sel_led) begin
            bus.ReadData = {24'h0, r_leds};
        end else if (w_sel_tx) begin
            bus.ReadData = {29'h0, r_overflow, w_full, w_empty};
        end else if (w_sel_timer) begin
            bus.ReadData = r_timer;
        end
    end

endmodule
